player_sprite_ctrl: RTL



---
 rtl/player_sprite_ctrl_pkg.sv | 25 ++
 rtl/player_sprite_ctrl_if.sv | 18 +
 rtl/player_sprite_ctrl_scan_counter.sv | 56 +++++
 rtl/player_sprite_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/player_sprite_ctrl_pkg.sv
// Shared definitions for the player-ship sprite controller: FSM encoding,
// default screen/sprite geometry and the two palette entries it uses.
package player_sprite_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2
    } sprite_state_e;

    localparam int DEF_XW       = 8;
    localparam int DEF_YW       = 7;
    localparam int DEF_CW       = 3;
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    localparam int DEF_SPR_W    = 8;
    localparam int DEF_SPR_H    = 4;
    localparam int DEF_STEP     = 1;
    localparam int DEF_INIT_X   = 76;
    localparam int DEF_INIT_Y   = 112;

    localparam logic [2:0] COL_BG   = 3'b000;
    localparam logic [2:0] COL_SHIP = 3'b010;

endpackage

// File: rtl/player_sprite_ctrl_if.sv
// Pixel-write channel towards the VGA adapter: one pixel offered per cycle,
// transferred when plot and plot_ready are both high.
interface player_sprite_ctrl_if
    import player_sprite_ctrl_pkg::*;
#(
    parameter int XW = DEF_XW,
    parameter int YW = DEF_YW,
    parameter int CW = DEF_CW
);
    logic          plot;
    logic          plot_ready;
    logic [XW-1:0] x_pos;
    logic [YW-1:0] y_pos;
    logic [CW-1:0] colour;

    modport master (output plot, output x_pos, output y_pos, output colour, input plot_ready);
    modport slave  (input plot, input x_pos, input y_pos, input colour, output plot_ready);
endinterface

// File: rtl/player_sprite_ctrl_scan_counter.sv
// Raster walker over the sprite box (col fast, row slow). Exposes the position
// the counter moves to on the coming edge so the caller can register pixel data.
module sprite_scan_counter
    import player_sprite_ctrl_pkg::*;
#(
    parameter int SPR_W = DEF_SPR_W,
    parameter int SPR_H = DEF_SPR_H,
    parameter int COLW  = (SPR_W > 1) ? $clog2(SPR_W) : 1,
    parameter int ROWW  = (SPR_H > 1) ? $clog2(SPR_H) : 1,
    parameter int IDXW  = (SPR_W * SPR_H > 1) ? $clog2(SPR_W * SPR_H) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            advance,
    output logic            last,
    output logic [COLW-1:0] nxt_col,
    output logic [ROWW-1:0] nxt_row,
    output logic [IDXW-1:0] nxt_idx
);
    logic [COLW-1:0] col;
    logic [ROWW-1:0] row;
    logic            last_col;

    assign last_col = (col == COLW'(SPR_W - 1));
    assign last     = last_col && (row == ROWW'(SPR_H - 1));

    always_comb begin
        nxt_col = col;
        nxt_row = row;
        if (clear) begin
            nxt_col = '0;
            nxt_row = '0;
        end else if (advance) begin
            if (last_col) begin
                nxt_col = '0;
                nxt_row = last ? '0 : row + ROWW'(1);
            end else begin
                nxt_col = col + COLW'(1);
            end
        end
    end

    assign nxt_idx = IDXW'(nxt_row) * IDXW'(SPR_W) + IDXW'(nxt_col);

    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else begin
            col <= nxt_col;
            row <= nxt_row;
        end
    end

endmodule

// File: rtl/player_sprite_ctrl.sv
// Player-ship controller: clamped per-frame moves, then erase of the old box
// and masked redraw streamed out as pixel writes over the plot handshake.
module player_sprite_ctrl
    import player_sprite_ctrl_pkg::*;
#(
    parameter int                          XW          = DEF_XW,
    parameter int                          YW          = DEF_YW,
    parameter int                          CW          = DEF_CW,
    parameter int                          SCREEN_W    = DEF_SCREEN_W,
    parameter int                          SCREEN_H    = DEF_SCREEN_H,
    parameter int                          SPR_W       = DEF_SPR_W,
    parameter int                          SPR_H       = DEF_SPR_H,
    parameter int                          STEP        = DEF_STEP,
    parameter int                          INIT_X      = DEF_INIT_X,
    parameter int                          INIT_Y      = DEF_INIT_Y,
    parameter logic [CW-1:0]               SHIP_COLOUR = CW'(COL_SHIP),
    parameter logic [CW-1:0]               BG_COLOUR   = CW'(COL_BG),
    parameter logic [SPR_W*SPR_H-1:0]      SPR_MASK    = '1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic                  mv_left,
    input  logic                  mv_right,
    input  logic                  mv_up,
    input  logic                  mv_down,
    player_sprite_ctrl_if.master  pix,
    output logic                  busy,
    output logic [XW-1:0]         ship_x,
    output logic [YW-1:0]         ship_y,
    output logic                  overrun
);
    localparam int COLW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROWW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int IDXW = (SPR_W * SPR_H > 1) ? $clog2(SPR_W * SPR_H) : 1;

    localparam logic signed [XW:0] X_MAX = (XW + 1)'(SCREEN_W - SPR_W);
    localparam logic signed [YW:0] Y_MAX = (YW + 1)'(SCREEN_H - SPR_H);

    function automatic logic [XW-1:0] sat_x(input logic signed [XW:0] v);
        if (v[XW])      return '0;
        if (v > X_MAX)  return X_MAX[XW-1:0];
        return v[XW-1:0];
    endfunction

    function automatic logic [YW-1:0] sat_y(input logic signed [YW:0] v);
        if (v[YW])      return '0;
        if (v > Y_MAX)  return Y_MAX[YW-1:0];
        return v[YW-1:0];
    endfunction

    sprite_state_e     state, state_n;
    logic              first_draw;
    logic [XW-1:0]     old_x, nx_x, base_x;
    logic [YW-1:0]     old_y, nx_y, base_y;
    logic signed [XW:0] dx, sum_x;
    logic signed [YW:0] dy, sum_y;
    logic              moved, pix_step;
    logic              cnt_clear, cnt_adv, pix_load, pix_erase, pix_stop, take_move;
    logic              last;
    logic [COLW-1:0]   nxt_col;
    logic [ROWW-1:0]   nxt_row;
    logic [IDXW-1:0]   nxt_idx;

    sprite_scan_counter #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .COLW  (COLW),
        .ROWW  (ROWW),
        .IDXW  (IDXW)
    ) u_scan (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .advance (cnt_adv),
        .last    (last),
        .nxt_col (nxt_col),
        .nxt_row (nxt_row),
        .nxt_idx (nxt_idx)
    );

    // Candidate position: one extra signed bit so underflow shows as negative.
    always_comb begin
        dx = '0;
        dy = '0;
        if (mv_right & ~mv_left)      dx = (XW + 1)'(STEP);
        else if (mv_left & ~mv_right) dx = -((XW + 1)'(STEP));
        if (mv_down & ~mv_up)         dy = (YW + 1)'(STEP);
        else if (mv_up & ~mv_down)    dy = -((YW + 1)'(STEP));
        sum_x = $signed({1'b0, ship_x}) + dx;
        sum_y = $signed({1'b0, ship_y}) + dy;
        nx_x  = sat_x(sum_x);
        nx_y  = sat_y(sum_y);
        moved = (nx_x != ship_x) || (nx_y != ship_y);
    end

    // A skipped (mask-0) slot never waits for plot_ready.
    assign pix_step = ~pix.plot | pix.plot_ready;
    assign busy     = (state != ST_IDLE);

    always_comb begin
        state_n   = state;
        cnt_clear = 1'b0;
        cnt_adv   = 1'b0;
        pix_load  = 1'b0;
        pix_erase = 1'b0;
        pix_stop  = 1'b0;
        take_move = 1'b0;
        base_x    = ship_x;
        base_y    = ship_y;
        case (state)
            ST_IDLE: begin
                if (frame_tick) begin
                    take_move = 1'b1;
                    if (first_draw) begin
                        state_n   = ST_DRAW;
                        cnt_clear = 1'b1;
                        pix_load  = 1'b1;
                        base_x    = nx_x;
                        base_y    = nx_y;
                    end else if (moved) begin
                        state_n   = ST_ERASE;
                        cnt_clear = 1'b1;
                        pix_load  = 1'b1;
                        pix_erase = 1'b1;
                    end
                end
            end
            ST_ERASE: begin
                if (pix_step) begin
                    pix_load = 1'b1;
                    if (last) begin
                        state_n   = ST_DRAW;
                        cnt_clear = 1'b1;
                    end else begin
                        cnt_adv   = 1'b1;
                        pix_erase = 1'b1;
                        base_x    = old_x;
                        base_y    = old_y;
                    end
                end
            end
            ST_DRAW: begin
                if (pix_step) begin
                    if (last) begin
                        state_n  = ST_IDLE;
                        pix_stop = 1'b1;
                    end else begin
                        cnt_adv  = 1'b1;
                        pix_load = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            first_draw <= 1'b1;
            ship_x     <= XW'(INIT_X);
            ship_y     <= YW'(INIT_Y);
            overrun    <= 1'b0;
            pix.plot   <= 1'b0;
            pix.x_pos  <= '0;
            pix.y_pos  <= '0;
            pix.colour <= '0;
        end else begin
            state <= state_n;
            if (take_move) begin
                ship_x     <= nx_x;
                ship_y     <= nx_y;
                first_draw <= 1'b0;
            end
            if (frame_tick && state != ST_IDLE) overrun <= 1'b1;
            if (pix_load) begin
                pix.plot   <= pix_erase | SPR_MASK[nxt_idx];
                pix.x_pos  <= base_x + XW'(nxt_col);
                pix.y_pos  <= base_y + YW'(nxt_row);
                pix.colour <= pix_erase ? BG_COLOUR : SHIP_COLOUR;
            end else if (pix_stop) begin
                pix.plot   <= 1'b0;
            end
        end
    end

    // Erase origin: position before the move, captured with the move itself.
    always_ff @(posedge clk) begin
        if (take_move) begin
            old_x <= ship_x;
            old_y <= ship_y;
        end
    end

endmodule
